// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the fetch/decode stage: RV64I opcodes, FSM state
// encoding and the default halt instruction.
package instr_fetch_decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ecall terminates the program
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_0073;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_HALT
    } state_t;

endpackage

// File: rtl/instr_fetch_decode_imm_gen.sv
// Combinational RV64I immediate generator: instruction word in, sign-extended
// immediate out. Unknown opcodes produce zero.
module imm_gen
    import instr_fetch_decode_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic [31:0]         i_instr,
    output logic [WORDSIZE-1:0] o_imm
);

    logic w_sign;
    assign w_sign = i_instr[31];

    always_comb begin
        o_imm = '0;
        case (i_instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                o_imm = {{(WORDSIZE-12){w_sign}}, i_instr[31:20]};
            OP_STORE:
                o_imm = {{(WORDSIZE-12){w_sign}}, i_instr[31:25], i_instr[11:7]};
            OP_BRANCH:
                o_imm = {{(WORDSIZE-13){w_sign}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                o_imm = {{(WORDSIZE-32){w_sign}}, i_instr[31:12], 12'b0};
            OP_JAL:
                o_imm = {{(WORDSIZE-21){w_sign}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
            default:
                o_imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode stage: owns the pc, reads the synchronous ROM and
// issues decoded fields over valid/ready. IFD_RETIRE_COUNT_EN adds retire_count.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int          WORDSIZE  = 64,
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                rom_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [31:0]         rom_data,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [6:0]          op_code,
    output logic [WORDSIZE-1:0] imm,
    output logic [ADDR_W+1:0]   pc,
    output logic                halted
`ifdef IFD_RETIRE_COUNT_EN
    ,
    output logic [31:0]         retire_count
`endif
);

    localparam logic [ADDR_W+1:0] PC_STEP = (ADDR_W+2)'(4);

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W+1:0]  r_pc;
    logic [31:0]        r_instr;
    logic               w_handshake;
    logic               w_is_halt;

    assign w_handshake = (r_state == ST_ISSUE) && issue_ready;
    assign w_is_halt   = (rom_data == HALT_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        rom_en       = 1'b0;
        issue_valid  = 1'b0;
        halted       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                rom_en       = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_next = w_is_halt ? ST_HALT : ST_ISSUE;
            end
            ST_ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready) w_state_next = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The halt word is never loaded, so fields keep the last issued instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            if (r_state == ST_WAIT && !w_is_halt) r_instr <= rom_data;
            if (w_handshake) r_pc <= r_pc + PC_STEP;
        end
    end

`ifdef IFD_RETIRE_COUNT_EN
    logic [31:0] r_retire_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_count <= '0;
        end else if (w_handshake) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign retire_count = r_retire_count;
`endif

    assign pc       = r_pc;
    assign rom_addr = r_pc[ADDR_W+1:2];
    assign rs1      = r_instr[19:15];
    assign rs2      = r_instr[24:20];
    assign rd       = r_instr[11:7];
    assign op_code  = r_instr[6:0];

    imm_gen #(
        .WORDSIZE (WORDSIZE)
    ) u_imm_gen (
        .i_instr (r_instr),
        .o_imm   (imm)
    );

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode with a 4-word ROM (ADDR_W=2).
// Covers reset, first-issue latency, back-pressure, halt, wrap and mid-issue reset.
module tb_instr_fetch_decode;

    localparam int WS = 64;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          issue_valid;
    logic          issue_ready;
    logic [4:0]    rs1, rs2, rd;
    logic [6:0]    op_code;
    logic [WS-1:0] imm;
    logic [AW+1:0] pc;
    logic          halted;
`ifdef IFD_RETIRE_COUNT_EN
    logic [31:0]   retire_count;
`endif

    logic [31:0] rom [4];
    int errors = 0;
    int checks = 0;

    instr_fetch_decode #(
        .WORDSIZE (WS),
        .ADDR_W   (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .op_code      (op_code),
        .imm          (imm),
        .pc           (pc),
        .halted       (halted)
`ifdef IFD_RETIRE_COUNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (issue_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk(tag, 64'(issue_valid), 64'd1);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        issue_ready = 1'b1;
        rom_data    = '0;

        // Program 1: addi, sd, ecall
        rom[0] = 32'h00A0_0093;
        rom[1] = 32'h0022_3423;
        rom[2] = 32'h0000_0073;
        rom[3] = 32'h0000_0013;
        do_reset();
        chk("rst_valid",  64'(issue_valid), 64'd0);
        chk("rst_rom_en", 64'(rom_en),      64'd0);
        chk("rst_addr",   64'(rom_addr),    64'd0);
        chk("rst_halted", 64'(halted),      64'd0);
        chk("rst_pc",     64'(pc),          64'd0);
        chk("rst_rd",     64'(rd),          64'd0);
        chk("rst_op",     64'(op_code),     64'd0);
        chk("rst_imm",    imm,              64'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c1_rom_en", 64'(rom_en),   64'd1);
        chk("c1_addr",   64'(rom_addr), 64'd0);
        tick();
        chk("c2_rom_en", 64'(rom_en),      64'd0);
        chk("c2_valid",  64'(issue_valid), 64'd0);
        tick();
        chk("c3_valid", 64'(issue_valid), 64'd1);
        chk("w0_rs1",   64'(rs1),         64'd0);
        chk("w0_rd",    64'(rd),          64'd1);
        chk("w0_op",    64'(op_code),     64'h13);
        chk("w0_imm",   imm,              64'h0000_0000_0000_000A);
        chk("w0_pc",    64'(pc),          64'd0);
        tick();
        chk("f1_rom_en", 64'(rom_en),   64'd1);
        chk("f1_addr",   64'(rom_addr), 64'd1);
        chk("f1_pc",     64'(pc),       64'd4);
        tick();
        tick();
        chk("w1_valid", 64'(issue_valid), 64'd1);
        chk("w1_rs1",   64'(rs1),         64'd4);
        chk("w1_rs2",   64'(rs2),         64'd2);
        chk("w1_op",    64'(op_code),     64'h23);
        chk("w1_imm",   imm,              64'h8);
        chk("w1_pc",    64'(pc),          64'd4);
`ifdef IFD_RETIRE_COUNT_EN
        chk("w1_retire", 64'(retire_count), 64'd1);
`endif
        tick();
        chk("f2_addr", 64'(rom_addr), 64'd2);
        tick();
        chk("wt2_valid", 64'(issue_valid), 64'd0);
        tick();
        chk("halt_flag", 64'(halted), 64'd1);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("halt_valid",  64'(issue_valid), 64'd0);
            chk("halt_rom_en", 64'(rom_en),      64'd0);
            chk("halt_flag_h", 64'(halted),      64'd1);
            tick();
        end
        start = 1'b0;
        chk("halt_op_kept", 64'(op_code), 64'h23);
        chk("halt_pc",      64'(pc),      64'd8);
`ifdef IFD_RETIRE_COUNT_EN
        chk("halt_retire", 64'(retire_count), 64'd2);
`endif

        // Program 2: back-pressure, then reset during ISSUE
        rom[0] = 32'hFFF0_0093;
        rom[2] = 32'h0000_0013;
        do_reset();
        chk("rst2_halted", 64'(halted), 64'd0);
        issue_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(issue_valid), 64'd1);
            chk("bp_imm",   imm,              64'hFFFF_FFFF_FFFF_FFFF);
            chk("bp_rd",    64'(rd),          64'd1);
            chk("bp_pc",    64'(pc),          64'd0);
            tick();
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("bp_done_valid",  64'(issue_valid), 64'd0);
        chk("bp_done_pc",     64'(pc),          64'd4);
        chk("bp_done_rom_en", 64'(rom_en),      64'd1);
        tick();
        tick();
        chk("pre_rst_valid", 64'(issue_valid), 64'd1);
        chk("pre_rst_pc",    64'(pc),          64'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid",  64'(issue_valid), 64'd0);
        chk("mid_rst_pc",     64'(pc),          64'd0);
        chk("mid_rst_rom_en", 64'(rom_en),      64'd0);
        chk("mid_rst_op",     64'(op_code),     64'd0);
`ifdef IFD_RETIRE_COUNT_EN
        chk("mid_rst_retire", 64'(retire_count), 64'd0);
`endif
        tick();
        chk("idle_rom_en", 64'(rom_en),      64'd0);
        chk("idle_valid",  64'(issue_valid), 64'd0);

        // Program 3: no halt word, pc wraps after four issues
        rom[0] = 32'h00A0_0093;
        rom[1] = 32'h0022_3423;
        rom[2] = 32'hFFF0_0093;
        rom[3] = 32'h0000_0013;
        issue_ready = 1'b1;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid("wrap_valid");
            chk("wrap_pc", 64'(pc), 64'(i * 4));
            tick();
        end
        chk("wrap_pc0",    64'(pc),       64'd0);
        chk("wrap_addr0",  64'(rom_addr), 64'd0);
        chk("wrap_rom_en", 64'(rom_en),   64'd1);
`ifdef IFD_RETIRE_COUNT_EN
        chk("wrap_retire", 64'(retire_count), 64'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Upstream stage of the processor register-file block.
- Fetches 32-bit RV64I instruction words from the synchronous instruction ROM and decodes rs1/rs2/rd/op_code/immediate.
- Issues the decoded fields to the register-file stage over a valid/ready handshake. Owns the program counter.

Parameters:
- WORDSIZE, 64, datapath width; width of the sign-extended immediate.
- ADDR_W, 5, ROM word-address width; ROM depth is 2^ADDR_W words.
- HALT_WORD, 32'h0000_0073, instruction encoding that stops fetching (ecall).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin fetching from pc=0; sampled only in IDLE.
- rom_en  out  1  ROM read enable, high for exactly one cycle per fetch.
- rom_addr  out  ADDR_W  ROM word address, equal to pc[ADDR_W+1:2].
- rom_data  in  32  ROM read data, valid the cycle after rom_en.
- issue_valid  out  1  decoded instruction available.
- issue_ready  in  1  register-file stage accepts the instruction.
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- rd  out  5  instr[11:7].
- op_code  out  7  instr[6:0].
- imm  out  WORDSIZE  sign-extended immediate.
- pc  out  ADDR_W+2  byte address of the instruction being fetched or issued.
- halted  out  1  HALT_WORD reached.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE; pc=0; instruction register=0.
  - rom_en=0, rom_addr=0, issue_valid=0, halted=0.
  - rs1/rs2/rd/op_code/imm=0.
- Reset asserted mid-operation: aborts any fetch or pending issue. issue_valid is low from the cycle after rst is sampled. No pc increment on that edge.
- FSM states: IDLE, FETCH, WAIT, ISSUE, HALT.
  - IDLE: start=1 -> FETCH. Otherwise stay.
  - FETCH: rom_en=1, rom_addr=pc[ADDR_W+1:2]. -> WAIT unconditionally.
  - WAIT: rom_data is valid this cycle and is registered into the instruction register.
    - rom_data==HALT_WORD -> HALT; the instruction register is not updated.
    - Otherwise -> ISSUE.
  - ISSUE: issue_valid=1. All decoded outputs stay stable while issue_ready=0.
    - On issue_valid&&issue_ready: pc<=pc+4, -> FETCH.
  - HALT: halted=1, issue_valid=0, rom_en=0. Exit only via rst.
- Latency:
  - start sampled at edge N: rom_en high in cycle N+1, issue_valid high from cycle N+3.
  - With issue_ready tied high, throughput is one instruction per 3 cycles.
- start is ignored outside IDLE.
- Decoded outputs are purely combinational from the instruction register.
- Immediate by op_code; all forms sign-extended from the top bit to WORDSIZE:
  - I-type (0000011, 0010011, 1100111): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Any other op_code: 0.
- Wrap-around: pc is ADDR_W+2 bits wide. Incrementing past the last ROM word wraps pc to 0 with no error.
- No branch handling; pc is strictly sequential.

Optional Feature:
- Macro: IFD_RETIRE_COUNT_EN.
- Defined:
  - Adds output port retire_count (32 bits).
  - Reset to 0; +1 on each issue handshake; wraps at 2^32.
  - Frozen in HALT.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR);
  - FSM state encoding;
  - HALT_WORD default.
- One sub-module, imm_gen: combinational, instruction in -> WORDSIZE immediate out, for reuse by later stages.
- The FSM and pc stay in instr_fetch_decode.

Test Plan:
- ROM[0]=32'h00A0_0093, start pulse, issue_ready=1 -> rom_en at cycle 1; issue_valid at cycle 3 with:
  - rs1=0, rd=1, op_code=7'b0010011;
  - imm=64'h0000_0000_0000_000A, pc=0.
- ROM[1]=32'h0022_3423 (sd x2,8(x4)) -> rs1=4, rs2=2, op_code=7'b0100011, imm=64'h8, pc=4.
- ROM[0]=32'hFFF0_0093, issue_ready=0 for 5 cycles -> issue_valid held and fields stable with:
  - imm=64'hFFFF_FFFF_FFFF_FFFF;
  - pc stays 0 until the handshake, then 4.
- ROM[2]=HALT_WORD -> after issuing words 0 and 1, halted=1, issue_valid never rises for word 2, rom_en stays 0; start is ignored.
- All ROM words non-halt, ADDR_W=2 -> after 4 issues, pc wraps to 0 and rom_addr=0.
- rst asserted during ISSUE with issue_ready=0 -> next cycle issue_valid=0, pc=0, state IDLE. With IFD_RETIRE_COUNT_EN defined, retire_count=0.
